clk_div_bank: RTL

//  Multi-channel programmable clock-enable and divided-clock generator fed from
//  the PLL core output (e.g. 16 MHz). It replaces fixed single-ratio PLL configs
//  for low-rate domains (1 MHz, baud, PWM bases).

---
 rtl/clk_div_bank_if.sv | 13 +
 rtl/clk_div_bank.sv | 105 ++++++++++
 2 files changed

// File: rtl/clk_div_bank_if.sv
// Configuration write port of clk_div_bank.
// Handshake: cfg_we is a one-cycle valid with no ready; every write on a valid channel is taken on the edge it is seen.
interface clk_div_bank_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 8
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_we, cfg_ch, cfg_div);
    modport slave  (input  cfg_we, cfg_ch, cfg_div);
endinterface

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers with glitch-free divisor updates,
// global phase realignment (sync) and a quiet-period LOCK indication.
module clk_div_bank #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 16,
    parameter int LOCK_CYCLES = 64
) (
    input  logic            REFERENCECLK,
    input  logic            RESET,
    clk_div_bank_if.slave   cfg,
    input  logic            sync,
    output logic [N_CH-1:0] ce,
    output logic [N_CH-1:0] clk_out,
    output logic            LOCK
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CH_W1 = CH_W + 1;
    localparam int LC_W  = $clog2(LOCK_CYCLES + 1);
    localparam logic [CH_W:0]    N_CH_L = CH_W1'(N_CH);
    localparam logic [DIV_W-1:0] DEF_L  = DIV_W'(DEFAULT_DIV);
    localparam logic [LC_W-1:0]  LOCK_L = LC_W'(LOCK_CYCLES);

    logic [DIV_W-1:0] cnt      [N_CH];
    logic [DIV_W-1:0] div_act  [N_CH];
    logic [DIV_W-1:0] shadow   [N_CH];
    logic [DIV_W-1:0] cnt_n    [N_CH];
    logic [DIV_W-1:0] div_n    [N_CH];
    logic [DIV_W-1:0] shadow_n [N_CH];
    logic [DIV_W:0]   half     [N_CH];
    logic [N_CH-1:0]  pend, pend_n, ce_n, clk_n, wr;
    logic [LC_W-1:0]  lock_cnt, lock_n;
    logic             accept;

    always_comb begin
        accept = cfg.cfg_we && ({1'b0, cfg.cfg_ch} < N_CH_L);
        wr     = '0;
        pend_n = '0;
        ce_n   = '0;
        clk_n  = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr[i]       = accept && (cfg.cfg_ch == CH_W'(i));
            shadow_n[i] = wr[i] ? cfg.cfg_div : shadow[i];
            pend_n[i]   = pend[i] | wr[i];
            div_n[i]    = div_act[i];
            cnt_n[i]    = '0;
            // Extra bit keeps (div+1)/2 exact at the top divisor.
            half[i]     = ({1'b0, div_act[i]} + 1'b1) >> 1;
            if (sync) begin
                if (pend_n[i]) div_n[i] = shadow_n[i];
                pend_n[i] = 1'b0;
            end else if (div_act[i] == '0) begin
                if (pend[i]) begin
                    div_n[i]  = shadow[i];
                    pend_n[i] = wr[i];
                end
            end else begin
                ce_n[i]  = (cnt[i] == div_act[i] - 1'b1);
                clk_n[i] = ({1'b0, cnt[i]} < half[i]);
                // Commit only on the wrap so no shortened pulse or phase appears.
                if (ce_n[i]) begin
                    if (pend[i]) begin
                        div_n[i]  = shadow[i];
                        pend_n[i] = wr[i];
                    end
                end else begin
                    cnt_n[i] = cnt[i] + 1'b1;
                end
            end
        end
        if (accept || sync)
            lock_n = '0;
        else if (lock_cnt == LOCK_L)
            lock_n = lock_cnt;
        else
            lock_n = lock_cnt + 1'b1;
    end

    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]     <= '0;
                div_act[i] <= DEF_L;
                shadow[i]  <= DEF_L;
            end
            pend     <= '0;
            ce       <= '0;
            clk_out  <= '0;
            lock_cnt <= '0;
            LOCK     <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]     <= cnt_n[i];
                div_act[i] <= div_n[i];
                shadow[i]  <= shadow_n[i];
            end
            pend     <= pend_n;
            ce       <= ce_n;
            clk_out  <= clk_n;
            lock_cnt <= lock_n;
            // LOCK follows the next-state values so it falls right after a clearing edge.
            LOCK     <= (lock_n == LOCK_L) && (pend_n == '0);
        end
    end
endmodule
